fetch_sequencer: RTL and testbench



---
 rtl/fetch_pkg.sv | 11 +
 rtl/fetch_buf.sv | 43 ++++
 rtl/fetch_sequencer.sv | 110 +++++++++++
 tb/tb_fetch_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared FSM encoding, reset PC default and fetch-entry layout for fetch_sequencer
package fetch_pkg;
  typedef enum logic [1:0] {S_BOOT, S_IDLE, S_REQ, S_DRAIN} state_t;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam int BUF_DEPTH = 2;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;
  localparam int ENTRY_W = $bits(fetch_entry_t);
endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: 2-entry IF/ID fetch FIFO with full flush and tail-only flush
//   clk, reset          clock, async active-high reset
//   push, push_data     enqueue one {instr, pc} entry
//   pop                 dequeue the head
//   flush               drop everything, including a same-cycle push
//   flush_tail          keep the head, drop the second entry
//   count, head         occupancy and head entry (zero when empty)
module fetch_buf
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  input  logic               flush,
  input  logic               flush_tail,
  output logic [1:0]         count,
  output logic [ENTRY_W-1:0] head
);
  logic [ENTRY_W-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0] cnt_q, cnt_d, kept, left;
  assign count = cnt_q;
  assign head = cnt_q != 2'd0 ? e0_q : '0;
  // tail drop happens before the pop, so pop+flush_tail leaves the buffer empty
  assign kept = flush_tail && cnt_q == 2'(BUF_DEPTH) ? 2'd1 : cnt_q;
  assign left = pop && kept != 2'd0 ? kept - 2'd1 : kept;
  always_comb begin
    e0_d = push && left == 2'd0 ? push_data : pop ? e1_q : e0_q;
    e1_d = push && left != 2'd0 ? push_data : e1_q;
    cnt_d = flush ? 2'd0 : left + {1'b0, push};
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      e0_q <= '0;
      e1_q <= '0;
      cnt_q <= 2'd0;
    end else begin
      e0_q <= e0_d;
      e1_q <= e1_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: MIPS fetch PC owner, single-outstanding imem requester and IF/ID buffer
//   clk, reset                     clock, async active-high reset
//   stall_i                        head not consumed this cycle
//   redirect_i, redirect_pc_i      branch/jump target from D (only when stall_i=0)
//   imem_req_o, imem_addr_o        instruction memory request
//   imem_ack_i, imem_rdata_i       response, may arrive in the request cycle
//   if_valid_o, if_instr_o,
//   if_pc_o, if_pc4_o              buffer head toward decode
// Build option DELAY_SLOT_EN: redirects keep the delay-slot instruction;
// undefined, a redirect squashes everything fetched after the branch.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_instr_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_pc4_o
);
  state_t state_q, state_d, next_norm;
  logic [31:0] fetch_pc_q, fetch_pc_d, drain_pc_q, drain_pc_d;
  logic [1:0] count, occ_pop;
  fetch_entry_t head;
  logic pop, push, flush, flush_tail, ack_req, busy;
  fetch_buf u_buf (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_data  ({imem_rdata_i, fetch_pc_q}),
    .pop        (pop),
    .flush      (flush),
    .flush_tail (flush_tail),
    .count      (count),
    .head       (head)
  );
  assign if_valid_o = count != 2'd0;
  assign if_instr_o = head.instr;
  assign if_pc_o = head.pc;
  assign if_pc4_o = head.pc + 32'd4;
  assign pop = if_valid_o && !stall_i;
  assign occ_pop = count - {1'b0, pop};
  assign imem_req_o = state_q == S_REQ || state_q == S_DRAIN;
  // a draining request keeps presenting the address it was issued with
  assign imem_addr_o = state_q == S_DRAIN ? drain_pc_q : fetch_pc_q;
  assign ack_req = imem_ack_i && state_q == S_REQ;
  assign busy = imem_req_o && !imem_ack_i;
  // keep requesting only while the buffer is guaranteed a free slot for the next ack
  always_comb begin
    next_norm = state_q == S_BOOT ? S_REQ :
                state_q == S_IDLE ? (occ_pop <= 2'd1 ? S_REQ : S_IDLE) :
                state_q == S_DRAIN ? (imem_ack_i ? S_REQ : S_DRAIN) :
                (imem_ack_i && occ_pop != 2'd0 ? S_IDLE : S_REQ);
    drain_pc_d = state_q == S_DRAIN ? drain_pc_q : fetch_pc_q;
  end
`ifdef DELAY_SLOT_EN
  logic pend_vld_q, pend_vld_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic rd_full, rd_empty;
  // non-empty: head is the delay slot, anything behind it is wrong-path
  // empty: the next returned word is the delay slot, target applied after it
  assign rd_full = redirect_i && if_valid_o;
  assign rd_empty = redirect_i && !if_valid_o;
  assign flush = 1'b0;
  assign flush_tail = rd_full;
  assign push = ack_req && !rd_full;
  always_comb begin
    state_d = rd_full ? (busy ? S_DRAIN : S_REQ) : next_norm;
    fetch_pc_d = rd_full || (rd_empty && ack_req) ? redirect_pc_i :
                 ack_req ? (pend_vld_q ? pend_pc_q : fetch_pc_q + 32'd4) : fetch_pc_q;
    pend_vld_d = rd_empty ? !ack_req : !rd_full && pend_vld_q && !ack_req;
    pend_pc_d = rd_empty ? redirect_pc_i : pend_pc_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pend_vld_q <= 1'b0;
      pend_pc_q <= '0;
    end else begin
      pend_vld_q <= pend_vld_d;
      pend_pc_q <= pend_pc_d;
    end
`else
  assign flush = redirect_i;
  assign flush_tail = 1'b0;
  assign push = ack_req && !redirect_i;
  always_comb begin
    state_d = redirect_i ? (busy ? S_DRAIN : S_REQ) : next_norm;
    fetch_pc_d = redirect_i ? redirect_pc_i : ack_req ? fetch_pc_q + 32'd4 : fetch_pc_q;
  end
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_BOOT;
      fetch_pc_q <= RESET_PC;
      drain_pc_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drain_pc_q <= drain_pc_d;
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed and randomized checks of fetch_sequencer against a program-order model
module tb_fetch_sequencer;
  logic clk = 1'b0;
  logic reset, stall_i, redirect_i, imem_ack_i, imem_req_o, if_valid_o;
  logic [31:0] redirect_pc_i, imem_addr_o, imem_rdata_i, if_instr_o, if_pc_o, if_pc4_o;
  int n_pass = 0, n_total = 0, n_fail = 0;
  bit mem_busy;
  logic [31:0] mem_addr;
  int mem_wait, lat_lo, lat_hi;
  logic [31:0] exp_pc, ds_target;
  bit ds_pend, ok_branch;
  int idle_run;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_rdata_i  (imem_rdata_i),
    .if_valid_o    (if_valid_o),
    .if_instr_o    (if_instr_o),
    .if_pc_o       (if_pc_o),
    .if_pc4_o      (if_pc4_o)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3C3_3C3C;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    imem_ack_i = 1'b0;
    stall_i = 1'b0;
    redirect_i = 1'b0;
    #3;
    chkb("rst_req", imem_req_o, 1'b0);
    chkb("rst_valid", if_valid_o, 1'b0);
    chk("rst_instr", if_instr_o, 32'h0);
    chk("rst_pc", if_pc_o, 32'h0);
    chk("rst_pc4", if_pc4_o, 32'h4);
    @(posedge clk);
    #1;
    reset = 1'b0;
    mem_busy = 1'b0;
    exp_pc = 32'h3000;
    ds_pend = 1'b0;
    ok_branch = 1'b0;
    idle_run = 0;
  endtask

  // one clock: drive inputs, answer memory, check head, advance the program-order model
  task automatic step(input bit st, input bit rd, input logic [31:0] tgt);
    bit take, was_ds;
    take = 1'b0;
    was_ds = 1'b0;
    stall_i = rd ? 1'b0 : st;
    redirect_i = rd;
    redirect_pc_i = tgt;
    imem_ack_i = 1'b0;
    imem_rdata_i = '0;
    if (mem_busy) begin
      chkb("req_held", imem_req_o, 1'b1);
      chk("addr_stable", imem_addr_o, mem_addr);
    end else if (imem_req_o) begin
      mem_busy = 1'b1;
      mem_addr = imem_addr_o;
      mem_wait = $urandom_range(lat_hi, lat_lo);
    end
    if (mem_busy && mem_wait == 0) begin
      imem_ack_i = 1'b1;
      imem_rdata_i = word_at(mem_addr);
      mem_busy = 1'b0;
    end else if (mem_busy) mem_wait--;
    if (if_valid_o) begin
      chk("pc4", if_pc4_o, if_pc_o + 32'd4);
      chk("instr", if_instr_o, word_at(if_pc_o));
    end
`ifdef DELAY_SLOT_EN
    take = if_valid_o && !stall_i;
`else
    take = if_valid_o && !stall_i && !rd;
`endif
    if (take) begin
      chk("pc_order", if_pc_o, exp_pc);
      was_ds = ds_pend;
      exp_pc = ds_pend ? ds_target : exp_pc + 32'd4;
      ds_pend = 1'b0;
    end
    if (rd) begin
`ifdef DELAY_SLOT_EN
      if (take) exp_pc = tgt;
      else begin
        ds_pend = 1'b1;
        ds_target = tgt;
      end
`else
      exp_pc = tgt;
`endif
    end
    ok_branch = take && !rd && !was_ds;
    idle_run = take ? 0 : stall_i ? idle_run : idle_run + 1;
    if (idle_run > 40) begin
      chk("progress_timeout", idle_run, 0);
      idle_run = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit rd, found;
    logic [31:0] tgt;
    int vcnt;
    reset = 1'b1;
    stall_i = 1'b0;
    redirect_i = 1'b0;
    redirect_pc_i = '0;
    imem_ack_i = 1'b0;
    imem_rdata_i = '0;
    lat_lo = 0;
    lat_hi = 0;
    do_reset();
    chkb("boot_req", imem_req_o, 1'b0);
    step(0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      chk("seq_addr", imem_addr_o, 32'h3000 + 32'(4 * k));
      chkb("seq_req", imem_req_o, 1'b1);
      if (k > 0) chk("seq_head", if_pc_o, 32'h3000 + 32'(4 * (k - 1)));
      step(0, 0, 0);
    end
    for (int k = 0; k < 5; k++) begin
      chk("stall_head", if_pc_o, 32'h3008);
      if (k > 0) chkb("stall_req", imem_req_o, 1'b0);
      step(1, 0, 0);
    end
    lat_lo = 3;
    lat_hi = 3;
    repeat (8) step(0, 0, 0);
    vcnt = 0;
    for (int k = 0; k < 16; k++) begin
      if (if_valid_o) vcnt++;
      step(0, 0, 0);
    end
    chk("lat3_valid_cnt", vcnt, 4);
    chkb("mid_req", imem_req_o, 1'b1);
    do_reset();
    lat_lo = 0;
    lat_hi = 0;
    step(0, 0, 0);
    chk("restart_addr", imem_addr_o, 32'h3000);
    repeat (5) step(0, 0, 0);
    chk("rd_full_branch", if_pc_o, 32'h3010);
    step(0, 0, 0);
    step(1, 0, 0);
    chk("rd_full_head", if_pc_o, 32'h3014);
    step(0, 1, 32'h3100);
    chk("rd_full_addr", imem_addr_o, 32'h3100);
    chkb("rd_full_req", imem_req_o, 1'b1);
    chkb("rd_full_valid", if_valid_o, 1'b0);
    repeat (6) step(0, 0, 0);
    do_reset();
    lat_lo = 2;
    lat_hi = 2;
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++)
      if (if_valid_o && if_pc_o == 32'h3010) found = 1'b1;
      else step(0, 0, 0);
    chkb("rd_empty_found", found, 1'b1);
    step(0, 0, 0);
    chkb("rd_empty_valid", if_valid_o, 1'b0);
    chk("rd_empty_out_addr", imem_addr_o, 32'h3014);
`ifdef DELAY_SLOT_EN
    tgt = 32'h3200;
`else
    tgt = 32'h3100;
`endif
    step(0, 1, tgt);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++)
      if (imem_req_o && imem_addr_o != 32'h3014) found = 1'b1;
      else step(0, 0, 0);
    chkb("rd_empty_next_found", found, 1'b1);
    chk("rd_empty_next_addr", imem_addr_o, tgt);
    repeat (10) step(0, 0, 0);
    lat_lo = 0;
    lat_hi = 3;
    for (int i = 0; i < 1500; i++) begin
      rd = ok_branch && $urandom_range(0, 4) == 0;
      tgt = $urandom_range(0, 9) == 0 ? 32'hFFFF_FFF0 : 32'h3000 + ($urandom_range(0, 1023) << 2);
      step($urandom_range(0, 3) == 0, rd, tgt);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
